v3a_shift_queue_ctrl: RTL and testbench

Controller that sequences a packed array of `p_depth` shift-capable queue slots (the v3a multi-input storage registers) as one ordered FIFO with optional push-front. Slot 0 is always the head; occupied slots are contiguous from 0 to `count-1`. It exposes valid/ready enqueue, dequeue and push-front ports and drives each slot's `wr_data`, `shift_en`, `set_occ` and `clr_occ` controls plus a shared write-data bus.

---
 rtl/v3a_shift_queue_ctrl.sv | 148 ++++++++++++++
 tb/tb_v3a_shift_queue_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/v3a_shift_queue_ctrl.sv
// Purpose : sequences p_depth shift-capable slots as one ordered FIFO (slot 0 = head), optional push-front.
// Latency : slot controls are combinational from count + handshakes; count/full/empty register one cycle later.
// Backpr. : enq/pushf accepted when not full or when a dequeue fires in the same cycle; flush blocks all ports.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   enq_*                    tail enqueue valid/ready + entry
//   pushf_*                  head insert valid/ready + entry (compiled in with V3A_QCTRL_PUSHF_EN)
//   deq_*                    head dequeue request/ready + head entry (= slot_data0)
//   flush                    synchronous clear of all slots
//   slot_data0               data_out of slot 0
//   slot_wr_data/_wr_data_in per-slot write enable and shared write bus
//   slot_shift_en            per-slot 2-bit shift code, bits [2i+1:2i] for slot i
//   slot_set_occ/_clr_occ    per-slot occupancy set/clear
//   count, full, empty       registered occupancy and its decodes
// Optional feature macro: V3A_QCTRL_PUSHF_EN
module v3a_shift_queue_ctrl #(
  parameter int p_depth     = 8,
  parameter int p_ptrwidth  = 5,
  parameter int p_chanwidth = 32,
  parameter int p_bitwidth  = p_ptrwidth + p_chanwidth,
  parameter int p_cntwidth  = $clog2(p_depth + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enq_val,
  output logic                    enq_rdy,
  input  logic [p_bitwidth-1:0]   enq_entry,
  input  logic                    pushf_val,
  output logic                    pushf_rdy,
  input  logic [p_bitwidth-1:0]   pushf_entry,
  input  logic                    deq_val,
  output logic                    deq_rdy,
  output logic [p_bitwidth-1:0]   deq_entry,
  input  logic                    flush,
  input  logic [p_bitwidth-1:0]   slot_data0,
  output logic [p_depth-1:0]      slot_wr_data,
  output logic [p_bitwidth-1:0]   slot_wr_data_in,
  output logic [2*p_depth-1:0]    slot_shift_en,
  output logic [p_depth-1:0]      slot_set_occ,
  output logic [p_depth-1:0]      slot_clr_occ,
  output logic [p_cntwidth-1:0]   count,
  output logic                    full,
  output logic                    empty
);

  // Shift codes shared with the slot registers.
  localparam logic [1:0] SHFT_IDLE = 2'b00;
  localparam logic [1:0] SHFT_FWD  = 2'b01;
  localparam logic [1:0] SHFT_REV  = 2'b10;

  logic [p_cntwidth-1:0] count_q;
  logic [p_cntwidth-1:0] count_d;
  logic                  enq_fire;
  logic                  deq_fire;
  logic                  pushf_fire;

  assign count     = count_q;
  assign full      = (count_q == p_cntwidth'(p_depth));
  assign empty     = (count_q == '0);
  assign deq_entry = slot_data0;

  // deq_fire only depends on deq_val and registered state, so feeding it
  // into the enqueue/push-front ready terms cannot form a loop.
  assign deq_rdy  = !empty && !flush;
  assign deq_fire = deq_val && deq_rdy;

`ifdef V3A_QCTRL_PUSHF_EN
  assign pushf_rdy       = (!full || deq_fire) && !flush;
  assign pushf_fire      = pushf_val && pushf_rdy;
  // Push-front wins over enqueue so the two never write in the same cycle.
  assign enq_rdy         = (!full || deq_fire) && !flush && !pushf_val;
  assign slot_wr_data_in = pushf_fire ? pushf_entry : enq_entry;
`else
  logic unused_pushf;
  assign unused_pushf    = ^{pushf_val, pushf_entry};
  assign pushf_rdy       = 1'b0;
  assign pushf_fire      = 1'b0;
  assign enq_rdy         = (!full || deq_fire) && !flush;
  assign slot_wr_data_in = enq_entry;
`endif

  assign enq_fire = enq_val && enq_rdy;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  // Next count: only one of enq/pushf can fire, so the net change is -1, 0 or +1.
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if ((enq_fire || pushf_fire) && !deq_fire) begin
      count_d = count_q + p_cntwidth'(1);
    end else if (deq_fire && !(enq_fire || pushf_fire)) begin
      count_d = count_q - p_cntwidth'(1);
    end
  end

  // Slot controls
  always_comb begin
    int c;
    c             = int'(count_q);
    slot_wr_data  = '0;
    slot_shift_en = {p_depth{SHFT_IDLE}};
    slot_set_occ  = '0;
    slot_clr_occ  = '0;
    if (flush) begin
      slot_clr_occ = '1;
    end else if (pushf_fire && deq_fire) begin
      // Head replaced in place; everything behind it stays put.
      slot_wr_data[0] = 1'b1;
`ifdef V3A_QCTRL_PUSHF_EN
    end else if (pushf_fire) begin
      // Slots 1..c load their lower neighbour; slot 0 takes the new entry.
      for (int i = 1; i < p_depth; i++) begin
        if (i <= c) slot_shift_en[2*i +: 2] = SHFT_REV;
      end
      slot_wr_data[0] = 1'b1;
      for (int i = 0; i < p_depth; i++) begin
        if (i == c) slot_set_occ[i] = 1'b1;
      end
`endif
    end else if (enq_fire && deq_fire) begin
      // Queue slides forward and the new entry lands in the vacated tail.
      for (int i = 0; i < p_depth; i++) begin
        if (i < c - 1)  slot_shift_en[2*i +: 2] = SHFT_FWD;
        if (i == c - 1) slot_wr_data[i] = 1'b1;
      end
    end else if (enq_fire) begin
      for (int i = 0; i < p_depth; i++) begin
        if (i == c) begin
          slot_wr_data[i] = 1'b1;
          slot_set_occ[i] = 1'b1;
        end
      end
    end else if (deq_fire) begin
      for (int i = 0; i < p_depth; i++) begin
        if (i < c - 1)  slot_shift_en[2*i +: 2] = SHFT_FWD;
        if (i == c - 1) slot_clr_occ[i] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_v3a_shift_queue_ctrl.sv
// Purpose : directed bench for v3a_shift_queue_ctrl with a behavioural slot array and an order scoreboard.
// Latency : checks combinational controls 1 ns after drive, registered state 1 ns after each rising edge.
// Backpr. : expected ready values are computed from the scoreboard occupancy and compared every step.
module tb_v3a_shift_queue_ctrl;

  localparam int D  = 8;
  localparam int BW = 37;
  localparam int CW = 4;
`ifdef V3A_QCTRL_PUSHF_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif
  localparam logic [1:0] S_FWD = 2'b01;
  localparam logic [1:0] S_REV = 2'b10;

  logic            clk = 1'b0;
  logic            rst;
  logic            enq_val, enq_rdy, pushf_val, pushf_rdy, deq_val, deq_rdy, flush;
  logic [BW-1:0]   enq_entry, pushf_entry, deq_entry, slot_data0, slot_wr_data_in;
  logic [D-1:0]    slot_wr_data, slot_set_occ, slot_clr_occ;
  logic [2*D-1:0]  slot_shift_en;
  logic [CW-1:0]   count;
  logic            full, empty;

  v3a_shift_queue_ctrl dut (
    .clk(clk), .rst(rst),
    .enq_val(enq_val), .enq_rdy(enq_rdy), .enq_entry(enq_entry),
    .pushf_val(pushf_val), .pushf_rdy(pushf_rdy), .pushf_entry(pushf_entry),
    .deq_val(deq_val), .deq_rdy(deq_rdy), .deq_entry(deq_entry),
    .flush(flush), .slot_data0(slot_data0),
    .slot_wr_data(slot_wr_data), .slot_wr_data_in(slot_wr_data_in),
    .slot_shift_en(slot_shift_en), .slot_set_occ(slot_set_occ), .slot_clr_occ(slot_clr_occ),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  // Behavioural slot array: a write overrides the shift code.
  logic [BW-1:0] slots [D];
  assign slot_data0 = slots[0];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < D; i++) slots[i] <= '0;
    end else begin
      for (int i = 0; i < D; i++) begin
        if (slot_wr_data[i])                     slots[i] <= slot_wr_data_in;
        else if (slot_shift_en[2*i +: 2] == S_FWD) slots[i] <= (i == D-1) ? '0 : slots[(i+1)%D];
        else if (slot_shift_en[2*i +: 2] == S_REV) slots[i] <= (i == 0) ? '0 : slots[(i+D-1)%D];
      end
    end
  end

  int checks = 0;
  int errors = 0;
  logic [BW-1:0] exp_q [$];
  bit            enq_f, deq_f, pf_f, fl_s;
  logic [BW-1:0] ee_s, pe_s;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs and check handshakes against the scoreboard.
  task automatic apply(input bit ev, input logic [BW-1:0] ee, input bit dv,
                       input bit pv, input logic [BW-1:0] pe, input bit fl);
    int n;
    bit isfull, isempty, drdy, prdy, erdy;
    logic [BW-1:0] got;
    enq_val = ev; enq_entry = ee; deq_val = dv; pushf_val = pv; pushf_entry = pe; flush = fl;
    #1;
    n       = exp_q.size();
    isfull  = (n == D);
    isempty = (n == 0);
    check("count", count, n);
    check("full", full, isfull);
    check("empty", empty, isempty);
    drdy  = !isempty && !fl;
    deq_f = dv && drdy;
    prdy  = PF && (!isfull || deq_f) && !fl;
    pf_f  = pv && prdy;
    erdy  = (!isfull || deq_f) && !fl && !(PF && pv);
    enq_f = ev && erdy;
    check("deq_rdy", deq_rdy, drdy);
    check("pushf_rdy", pushf_rdy, prdy);
    check("enq_rdy", enq_rdy, erdy);
    if (deq_f) begin
      got = exp_q.pop_front();
      check("deq_entry", deq_entry, got);
    end
    if (pf_f)       check("wr_bus_pushf", slot_wr_data_in, pe);
    else if (enq_f) check("wr_bus_enq", slot_wr_data_in, ee);
    fl_s = fl; ee_s = ee; pe_s = pe;
  endtask

  task automatic commit();
    @(posedge clk); #1;
    if (fl_s) exp_q.delete();
    else begin
      if (pf_f)  exp_q.push_front(pe_s);
      if (enq_f) exp_q.push_back(ee_s);
    end
    enq_val = 0; deq_val = 0; pushf_val = 0; flush = 0;
  endtask

  task automatic fill8();
    for (int k = 0; k < D; k++) begin
      apply(1, BW'(32'h11 + k), 0, 0, '0, 0);
      check("fill_wr", slot_wr_data, 8'(1) << k);
      check("fill_set", slot_set_occ, 8'(1) << k);
      commit();
    end
  endtask

  task automatic deq_n(input int n);
    for (int k = 0; k < n; k++) begin
      apply(0, '0, 1, 0, '0, 0);
      commit();
    end
  endtask

  initial begin
    rst = 1; enq_val = 0; deq_val = 0; pushf_val = 0; flush = 0;
    enq_entry = '0; pushf_entry = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    rst = 0;

    // Reset ready values with pushf_val high and enq_val low.
    apply(0, '0, 0, 1, BW'(32'h3), 0);
    commit();
    deq_n(exp_q.size());

    // Fill, check head and full back-pressure, then drain in order.
    fill8();
    apply(1, BW'(32'h55), 0, 0, '0, 0);
    check("full_head", deq_entry, 32'h11);
    commit();
    for (int k = 0; k < D; k++) begin
      apply(0, '0, 1, 0, '0, 0);
      check("drain_clr", slot_clr_occ, 8'(1) << (D-1-k));
      commit();
    end
    apply(0, '0, 0, 0, '0, 0);
    commit();

    // Simultaneous enqueue and dequeue on a full queue.
    fill8();
    apply(1, BW'(32'h99), 1, 0, '0, 0);
    check("ed_wr", slot_wr_data, 8'h80);
    check("ed_shift", slot_shift_en, 16'h1555);
    check("ed_set", slot_set_occ, 0);
    check("ed_clr", slot_clr_occ, 0);
    commit();
    check("ed_slot7", slots[7], 32'h99);
    check("ed_head", deq_entry, 32'h12);

    // Flush at count 5 with enq and deq requested.
    deq_n(3);
    apply(1, BW'(32'h77), 1, 0, '0, 1);
    check("fl_clr", slot_clr_occ, 8'hFF);
    check("fl_wr", slot_wr_data, 0);
    check("fl_shift", slot_shift_en, 0);
    check("fl_set", slot_set_occ, 0);
    commit();
    apply(0, '0, 0, 0, '0, 0);
    commit();

`ifdef V3A_QCTRL_PUSHF_EN
    apply(1, BW'(32'hA), 0, 0, '0, 0); commit();
    apply(1, BW'(32'hB), 0, 0, '0, 0); commit();
    apply(1, BW'(32'hC), 0, 1, BW'(32'h5), 0);
    check("pf_shift", slot_shift_en, 16'h0028);
    check("pf_wr", slot_wr_data, 8'h01);
    check("pf_set", slot_set_occ, 8'h04);
    commit();
    deq_n(3);
    apply(1, BW'(32'hA), 0, 0, '0, 0); commit();
    apply(1, BW'(32'hB), 0, 0, '0, 0); commit();
    apply(0, '0, 1, 1, BW'(32'h7), 0);
    check("pfd_wr", slot_wr_data, 8'h01);
    check("pfd_shift", slot_shift_en, 0);
    check("pfd_set", slot_set_occ, 0);
    check("pfd_clr", slot_clr_occ, 0);
    commit();
    check("pfd_slot0", slots[0], 32'h7);
    check("pfd_slot1", slots[1], 32'hB);
    deq_n(2);
`else
    apply(1, BW'(32'hA), 0, 0, '0, 0); commit();
    apply(1, BW'(32'hB), 0, 1, BW'(32'h5), 0);
    check("nopf_shift", slot_shift_en, 0);
    check("nopf_wr", slot_wr_data, 8'h02);
    commit();
    deq_n(2);
`endif

    // Asynchronous reset in the middle of a cycle.
    apply(1, BW'(32'h1), 0, 0, '0, 0); commit();
    apply(1, BW'(32'h2), 0, 0, '0, 0); commit();
    apply(1, BW'(32'h3), 0, 0, '0, 0); commit();
    #2;
    rst = 1;
    #1;
    check("arst_count", count, 0);
    check("arst_empty", empty, 1);
    rst = 0;
    exp_q.delete();
    apply(0, '0, 0, 0, '0, 0);
    commit();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
